decade_chain_ctrl: RTL
======================

# decade_chain_ctrl

Sequencing controller for a chain of `DIGITS` external 4-bit decimal (0–9) counters.
- Turns start/stop/clear button levels into a run/hold/done state machine.
- Divides `clk` into count ticks.
- Drives per-counter increment-enable pulses, carrying from the low digit upward, plus a shared synchronous-clear pulse.
- Sits between the front-panel inputs and the decimal counter instances. It reads the counters' current values back to form carries and to detect an optional terminal value.

## Interface

Parameters:
- `DIGITS`, 2: number of cascaded decimal counters controlled (1–8).
- `PRESCALE`, 4: `clk` cycles per count tick (≥ 2).

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  level input; rising edge = start/resume request.
- `stop`  in  1  level input; rising edge = pause request.
- `clear`  in  1  level input; rising edge = clear request.
- `digits`  in  4*DIGITS  current counter values; digit i on [4i+3:4i], digit 0 least significant.
- `limit`  in  4*DIGITS  BCD terminal value, same packing.
- `limit_en`  in  1  1 = stop at `limit`; 0 = free-run with wrap.
- `cnt_en`  out  DIGITS  one-cycle increment enables, bit i to counter i.
- `cnt_clr`  out  1  one-cycle synchronous clear to all counters.
- `running`  out  1  high in RUN.
- `done`  out  1  high in DONE.

## Operation

Edge detection:
- One `prev_*` register per button input; reset 0.
- Event = `in & ~prev_in`, evaluated combinationally in the same cycle.
- Simultaneous events, priority: clear > stop > start.

FSM states: IDLE, RUN, HOLD, DONE. Reset state is IDLE.

- **IDLE**
  - start → RUN; prescaler := 0.
  - clear → `cnt_clr` pulse; stay in IDLE.
  - stop → ignored.
- **RUN**
  - Prescaler counts 0..PRESCALE-1 and wraps. Tick = prescaler == PRESCALE-1 while in RUN.
  - On a tick with `limit_en`=1 and `digits` == `limit`: → DONE, no `cnt_en`.
  - On any other tick: `cnt_en[0]`=1. `cnt_en[i]`=1 iff digits 0..i-1 are all 9 (ripple carry from sampled `digits`).
  - stop → HOLD; prescaler value retained.
  - clear → `cnt_clr` pulse, → IDLE, prescaler := 0.
  - A stop or clear event in a tick cycle suppresses that tick's `cnt_en`.
- **HOLD**
  - start → RUN; prescaler resumes from its held value.
  - clear → `cnt_clr`, → IDLE.
  - No ticks.
- **DONE**
  - clear → `cnt_clr`, → IDLE.
  - start and stop ignored.

Arithmetic and boundaries:
- Digits ≥ 10 on `digits` are treated as "not 9" for carry purposes.
- Wrap-around: all digits 9 at a tick → every `cnt_en` bit set; the counters wrap to 0 externally. This happens only when `limit_en`=0 or `limit` differs from all-9s.
- If `limit_en` is first raised while `digits` is already past `limit`, no stop occurs until the count wraps around to `limit`.

## Timing

- Reset values: state IDLE, prescaler 0, `prev_*` 0, and all outputs 0 (`cnt_en`, `cnt_clr`, `running`, `done`).
- `rst` assertion mid-operation forces these values immediately (asynchronous). Counting resumes only after a fresh start edge.
- `cnt_en` and `cnt_clr` are registered: asserted exactly one cycle, in the cycle after the decision edge.
- `running` and `done` are decoded from the state register.
- Start latency: start rises before edge k → `running`=1 after edge k. The first tick decision falls at edge k+PRESCALE-1, and `cnt_en` is high from edge k+PRESCALE to k+PRESCALE+1. Counters update at edge k+PRESCALE+1.
- Steady-state `cnt_en` period = PRESCALE cycles.
- PRESCALE ≥ 2 guarantees `digits` reflects the previous increment before the next tick samples it.
- Holding a button high produces only one event; it must return low for at least one sampled edge before it can re-trigger.

## Test plan

All scenarios use DIGITS=2, PRESCALE=4, and a bench model of two decimal counters.

- **Reset:** pulse `rst` mid-RUN, asynchronously between edges → all outputs 0 immediately. No `cnt_en` until the next start edge.
- **Basic count:** start pulse, `limit_en`=0 → first `cnt_en`=01 exactly 4 edges after start. Digits step 00,01,…,09. At 09 → `cnt_en`=11, giving 10.
- **Wrap:** run from 99 → `cnt_en`=11 → digits 00. `running` stays 1.
- **Pause/resume:** stop at prescaler=2 → no `cnt_en` during HOLD (≥ 20 cycles). After start, the next `cnt_en` arrives 2 edges later.
- **Limit:** `limit`=0x12, `limit_en`=1, start from 00 → counting halts at 12, `done`=1, `running`=0. A start edge in DONE is ignored. Clear → `cnt_clr` pulse, IDLE, digits 00.
- **Simultaneous events:** start+stop+clear rise on the same edge in RUN → `cnt_clr` 1 cycle, state IDLE, no `cnt_en`. Start+stop together in IDLE → IDLE, since stop wins.

Source files
------------

// File: rtl/decade_chain_ctrl.sv
// Sequencing controller for a chain of cascaded decimal counters: button edge
// detection, run/hold/done control, count-tick prescaler and ripple-carry enables.
module decade_chain_ctrl #(
    parameter int DIGITS   = 2,
    parameter int PRESCALE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
    input  logic [4*DIGITS-1:0]   digits,
    input  logic [4*DIGITS-1:0]   limit,
    input  logic                  limit_en,
    output logic [DIGITS-1:0]     cnt_en,
    output logic                  cnt_clr,
    output logic                  running,
    output logic                  done,
    output logic [1:0]            state_dbg
);

    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic                prev_start_q, prev_stop_q, prev_clear_q;
    logic [DIGITS-1:0]   cnt_en_q, cnt_en_d;
    logic                cnt_clr_q, cnt_clr_d;

    logic                start_ev, stop_ev, clear_ev;
    logic                tick, at_limit;
    logic [DIGITS-1:0]   carry_mask;

    always_comb begin
        start_ev = start & ~prev_start_q;
        stop_ev  = stop  & ~prev_stop_q;
        clear_ev = clear & ~prev_clear_q;
        tick     = (state_q == S_RUN) && (presc_q == PRESC_MAX);
        at_limit = limit_en && (digits == limit);
    end

    // Digit i advances only when every lower digit reads exactly 9; invalid codes never carry.
    always_comb begin
        carry_mask    = '0;
        carry_mask[0] = 1'b1;
        for (int i = 1; i < DIGITS; i++) begin
            carry_mask[i] = carry_mask[i-1] & (digits[4*(i-1) +: 4] == 4'd9);
        end
    end

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        cnt_en_d  = '0;
        cnt_clr_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (clear_ev) begin
                    cnt_clr_d = 1'b1;
                end else if (start_ev && !stop_ev) begin
                    state_d = S_RUN;
                    presc_d = '0;
                end
            end
            S_RUN: begin
                if (clear_ev) begin
                    cnt_clr_d = 1'b1;
                    state_d   = S_IDLE;
                    presc_d   = '0;
                end else if (stop_ev) begin
                    state_d = S_HOLD;
                end else if (tick) begin
                    presc_d = '0;
                    if (at_limit) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_en_d = carry_mask;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            S_HOLD: begin
                // Prescaler is frozen here so a resume continues the interrupted tick period.
                if (clear_ev) begin
                    cnt_clr_d = 1'b1;
                    state_d   = S_IDLE;
                    presc_d   = '0;
                end else if (start_ev && !stop_ev) begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (clear_ev) begin
                    cnt_clr_d = 1'b1;
                    state_d   = S_IDLE;
                    presc_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                presc_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            presc_q      <= '0;
            prev_start_q <= 1'b0;
            prev_stop_q  <= 1'b0;
            prev_clear_q <= 1'b0;
            cnt_en_q     <= '0;
            cnt_clr_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            prev_start_q <= start;
            prev_stop_q  <= stop;
            prev_clear_q <= clear;
            cnt_en_q     <= cnt_en_d;
            cnt_clr_q    <= cnt_clr_d;
        end
    end

    assign cnt_en    = cnt_en_q;
    assign cnt_clr   = cnt_clr_q;
    assign running   = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign state_dbg = state_q;

endmodule
